fact_bus_master: RTL and testbench

- Bus initiator that drives the memory-mapped factorial accelerator through its 2-bit address / write-enable / data port.
- Accepts one job (n) per valid/ready request from the host side.
- Sequences: write n, pulse Go, poll status, read result.
- Returns the result or an error on a valid/ready response channel.

---
 rtl/fact_bus_master.sv | 161 ++++++++++++++++
 tb/tb_fact_bus_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fact_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : fact_bus_master
//  Description : Bus initiator for the memory-mapped factorial accelerator.
//                Takes one operand per valid/ready request, writes n, pulses
//                Go, polls status (bounded by POLL_MAX), reads the result and
//                returns it (or an error/timeout) on a valid/ready response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fact_bus_master #(
  parameter int N_W      = 4,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [N_W-1:0]    req_n,
  output logic              req_ready,
  output logic [1:0]        A,
  output logic              WE,
  output logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] RD,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_err,
  output logic              resp_timeout
);

  // One extra bit over clog2 so the counter can never wrap before the limit test.
  localparam int                CNT_W    = $clog2(POLL_MAX) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(POLL_MAX - 1);

  localparam logic [1:0] ADDR_N      = 2'b00;
  localparam logic [1:0] ADDR_GO     = 2'b01;
  localparam logic [1:0] ADDR_STATUS = 2'b10;
  localparam logic [1:0] ADDR_RESULT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_POLL   = 3'd3,
    S_RD_RES = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_a;
  logic                r_we;
  logic [DATA_W-1:0]   r_wd;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_result;
  logic                r_err;
  logic                r_timeout;

  // Single FSM: bus outputs are loaded together with the state they belong
  // to, so they are pure functions of the state register and never see RD,
  // req_valid or resp_ready combinationally. The WD register doubles as the
  // latched operand while in WR_N.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= ADDR_N;
      r_we         <= 1'b0;
      r_wd         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state     <= S_WR_N;
            r_a         <= ADDR_N;
            r_we        <= 1'b1;
            r_wd        <= DATA_W'(req_n);
            r_req_ready <= 1'b0;
          end
        end
        S_WR_N: begin
          r_state <= S_WR_GO;
          r_a     <= ADDR_GO;
          r_we    <= 1'b1;
          r_wd    <= DATA_W'(1);
        end
        S_WR_GO: begin
          r_state <= S_POLL;
          r_cnt   <= '0;
          r_a     <= ADDR_STATUS;
          r_we    <= 1'b0;
          r_wd    <= '0;
        end
        S_POLL: begin
          // Err outranks Done; Done outranks the timeout on the last poll.
          if (RD[1]) begin
            r_state      <= S_RESP;
            r_a          <= ADDR_N;
            r_resp_valid <= 1'b1;
            r_result     <= '0;
            r_err        <= 1'b1;
            r_timeout    <= 1'b0;
          end else if (RD[0]) begin
            r_state <= S_RD_RES;
            r_a     <= ADDR_RESULT;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= S_RESP;
            r_a          <= ADDR_N;
            r_resp_valid <= 1'b1;
            r_result     <= '0;
            r_err        <= 1'b1;
            r_timeout    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_RES: begin
          r_state      <= S_RESP;
          r_a          <= ADDR_N;
          r_resp_valid <= 1'b1;
          r_result     <= RD;
          r_err        <= 1'b0;
          r_timeout    <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_a          <= ADDR_N;
          r_we         <= 1'b0;
          r_wd         <= '0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign A            = r_a;
  assign WE           = r_we;
  assign WD           = r_wd;
  assign resp_valid   = r_resp_valid;
  assign resp_result  = r_result;
  assign resp_err     = r_err;
  assign resp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fact_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fact_bus_master
//  Description : Self-checking bench for fact_bus_master with a small
//                behavioural accelerator model and a bus-trace monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fact_bus_master;

  localparam int N_W      = 4;
  localparam int DATA_W   = 32;
  localparam int POLL_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [N_W-1:0]    req_n;
  logic              req_ready;
  logic [1:0]        A;
  logic              WE;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] RD;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_err;
  logic              resp_timeout;

  always #5 clk = ~clk;

  fact_bus_master #(.N_W(N_W), .DATA_W(DATA_W), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .A(A), .WE(WE), .WD(WD), .RD(RD),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err), .resp_timeout(resp_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- accelerator model ----------------
  int         m_done_at = 0;   // Done visible on this poll cycle (1-based), 0 = never
  bit         m_errm    = 1'b0;
  logic [3:0] m_n       = '0;
  int         m_pcnt    = 0;
  bit         m_active  = 1'b0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (WE && A == 2'b00) m_n <= WD[3:0];
    if (WE && A == 2'b01) begin
      m_pcnt   <= 0;
      m_active <= 1'b1;
    end else if (A == 2'b10) begin
      m_pcnt <= m_pcnt + 1;
    end
  end

  always_comb begin
    logic done_b, err_b;
    RD     = '0;
    err_b  = m_active && m_errm;
    done_b = err_b || (m_active && m_done_at != 0 && m_pcnt >= m_done_at - 1);
    if (A == 2'b10)      RD = {30'd0, err_b, done_b};
    else if (A == 2'b11) RD = fact(m_n);
  end

  // ---------------- bus trace monitor ----------------
  int          c_poll = 0, c_rd = 0, c_w00 = 0, c_w01 = 0, c_wother = 0;
  logic [31:0] c_wd00 = '0, c_wd01 = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (A == 2'b10) c_poll++;
      if (A == 2'b11) c_rd++;
      if (WE) begin
        if (A == 2'b00)      begin c_w00++; c_wd00 = WD; end
        else if (A == 2'b01) begin c_w01++; c_wd01 = WD; end
        else                 c_wother++;
      end
    end
  end

  task automatic clr_trace();
    c_poll = 0; c_rd = 0; c_w00 = 0; c_w01 = 0; c_wother = 0;
  endtask

  // Waits (at negedges) for resp_valid; returns cycles since the accept edge.
  task automatic wait_resp(output bit seen, output int lat);
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    if (!seen) chk("resp_timeout_wait", 32'd0, 32'd1);
  endtask

  // Full job with resp_ready held high; called and returns at a negedge.
  task automatic run_job(input logic [3:0] n, input int done_at, input bit errm,
                         input logic [31:0] er, input bit ee, input bit et,
                         input int ep, input int erd, input int elat);
    bit seen;
    int lat;
    int w;
    m_done_at = done_at;
    m_errm    = errm;
    clr_trace();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_n      = n;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) chk("req_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(seen, lat);
    if (seen) begin
      chk("result",   resp_result, er);
      chk("err",      32'(resp_err), 32'(ee));
      chk("timeout",  32'(resp_timeout), 32'(et));
      chk("polls",    32'(c_poll), 32'(ep));
      chk("rd_cycles",32'(c_rd), 32'(erd));
      chk("wr00",     32'(c_w00), 32'd1);
      chk("wr00_wd",  c_wd00, 32'(n));
      chk("wr01",     32'(c_w01), 32'd1);
      chk("wr01_wd",  c_wd01, 32'd1);
      chk("wr_other", 32'(c_wother), 32'd0);
      if (elat >= 0) chk("latency", 32'(lat), 32'(elat));
    end
    @(negedge clk);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    chk("resp_valid_after", 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  n;
    int          done_at;
    bit          errm;
    logic [31:0] res;
    bit          err;
    bit          to;
    int          polls;
    int          rdres;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen;
    int lat;

    //           n   done err  result      err to polls rd lat
    vecs[0] = '{4'd5,  6, 1'b0, 32'd120,       1'b0, 1'b0, 6, 1, 10};
    vecs[1] = '{4'd12, 1, 1'b0, 32'd479001600, 1'b0, 1'b0, 1, 1, 5};
    vecs[2] = '{4'd13, 1, 1'b1, 32'd0,         1'b1, 1'b0, 1, 0, 4};
    vecs[3] = '{4'd7,  0, 1'b0, 32'd0,         1'b1, 1'b1, 8, 0, 11};
    vecs[4] = '{4'd10, 8, 1'b0, 32'd3628800,   1'b0, 1'b0, 8, 1, 12};
    vecs[5] = '{4'd0,  2, 1'b0, 32'd1,         1'b0, 1'b0, 2, 1, 6};

    rst_n = 1'b0; req_valid = 1'b0; req_n = '0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_A",         32'(A), 32'd0);
    chk("rst_WE",        32'(WE), 32'd0);
    chk("rst_WD",        WD, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp",      {28'd0, resp_valid, resp_err, resp_timeout, 1'b0}, 32'd0);
    chk("rst_result",    resp_result, 32'd0);

    for (int i = 0; i < 6; i++)
      run_job(vecs[i].n, vecs[i].done_at, vecs[i].errm, vecs[i].res,
              vecs[i].err, vecs[i].to, vecs[i].polls, vecs[i].rdres, vecs[i].lat);

    // Back-pressure: response held, new request presented but ignored.
    m_done_at = 1; m_errm = 1'b0;
    resp_ready = 1'b0; req_valid = 1'b1; req_n = 4'd2;
    @(negedge clk);
    req_n = 4'd3;
    wait_resp(seen, lat);
    clr_trace();
    for (int i = 0; i < 10; i++) begin
      chk("hold_flags", {27'd0, resp_valid, req_ready, WE, resp_err, resp_timeout}, 32'b10000);
      chk("hold_result", resp_result, 32'd2);
      @(negedge clk);
    end
    chk("hold_writes", 32'(c_w00 + c_w01 + c_wother), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release_resp_valid", 32'(resp_valid), 32'd0);
    chk("release_req_ready",  32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("queued_accept", 32'(req_ready), 32'd0);
    wait_resp(seen, lat);
    chk("queued_result", resp_result, 32'd6);
    chk("queued_wd00",   c_wd00, 32'd3);
    @(negedge clk);

    // Reset in the middle of polling drops the job.
    m_done_at = 0; m_errm = 1'b0;
    req_valid = 1'b1; req_n = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_poll_A", 32'(A), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("poll_rst_A",         32'(A), 32'd0);
    chk("poll_rst_WE",        32'(WE), 32'd0);
    chk("poll_rst_req_ready", 32'(req_ready), 32'd1);
    chk("poll_rst_resp",      {29'd0, resp_valid, resp_err, resp_timeout}, 32'd0);
    run_job(4'd4, 1, 1'b0, 32'd24, 1'b0, 1'b0, 1, 1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
